jtag_host_driver: RTL

- Upstream JTAG master in the sys_clk domain. Drives tck/tms/tdi/trst into jtag_test_logic and samples its tdo.
- Takes one command at a time (TAP reset, IR scan, DR scan, idle clocks), walks the TAP state machine from Run-Test/Idle and back, and returns captured tdo bits.
- Used by on-chip self-test and by the bench as the host-side JTAG stimulus generator.

---
 rtl/jtag_host_pkg.sv | 32 +++
 rtl/jtag_tck_gen.sv | 49 ++++
 rtl/jtag_host_driver.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/jtag_host_pkg.sv
// rtl/jtag_host_pkg.sv - shared types and TMS walk sequences for the JTAG host driver
package jtag_host_pkg;

    typedef enum logic [1:0] {
        OP_TAP_RESET = 2'd0,
        OP_SCAN_IR   = 2'd1,
        OP_SCAN_DR   = 2'd2,
        OP_IDLE_CLKS = 2'd3
    } jtag_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRST,
        ST_PRE,
        ST_SHIFT,
        ST_POST,
        ST_RESP
    } host_state_t;

    localparam int SEQ_W = 6;

    // TMS walks are sent LSB first, one bit per tck
    localparam logic [SEQ_W-1:0] TMS_RESET      = 6'b011111;
    localparam int               TMS_RESET_LEN  = 6;
    localparam logic [SEQ_W-1:0] TMS_PRE_IR     = 6'b000011;
    localparam int               TMS_PRE_IR_LEN = 4;
    localparam logic [SEQ_W-1:0] TMS_PRE_DR     = 6'b000001;
    localparam int               TMS_PRE_DR_LEN = 3;
    localparam logic [SEQ_W-1:0] TMS_POST       = 6'b000001;
    localparam int               TMS_POST_LEN   = 2;

endpackage

// File: rtl/jtag_tck_gen.sv
// rtl/jtag_tck_gen.sv - tck divider: low phase then high phase, DIV sys_clk cycles each
module jtag_tck_gen #(
    parameter int DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    output logic tck_o,
    output logic rise_stb_o,
    output logic fall_stb_o
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tck_q, tck_d;
    logic          wrap;

    assign wrap = run_i && (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        tck_d = tck_q;
        if (!run_i) begin
            cnt_d = '0;
            tck_d = 1'b0;
        end else if (wrap) begin
            cnt_d = '0;
            tck_d = ~tck_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end

    // strobes mark the sys_clk cycle whose closing edge moves tck
    assign rise_stb_o = wrap && !tck_q;
    assign fall_stb_o = wrap && tck_q;
    assign tck_o      = tck_q;

endmodule

// File: rtl/jtag_host_driver.sv
// rtl/jtag_host_driver.sv - JTAG host command engine; JTAG_HOST_AUTO_RESET_EN self-issues a TAP reset after reset
module jtag_host_driver
    import jtag_host_pkg::*;
#(
    parameter int DIV     = 4,
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               sys_clk_i,
    input  logic               reset_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [1:0]         cmd_op_i,
    input  logic [LEN_W-1:0]   cmd_len_i,
    input  logic [MAX_LEN-1:0] cmd_data_i,
    output logic               rsp_valid_o,
    output logic [MAX_LEN-1:0] rsp_data_o,
    output logic               tck_o,
    output logic               tms_o,
    output logic               tdi_o,
    output logic               trst_o,
    input  logic               tdo_i
);
    localparam int TW = $clog2(2 * DIV + 1);
`ifdef JTAG_HOST_AUTO_RESET_EN
    localparam logic AUTO_INIT = 1'b1;
`else
    localparam logic AUTO_INIT = 1'b0;
`endif

    host_state_t        state_q, state_d;
    jtag_op_t           op_q, op_d, new_op;
    logic [LEN_W-1:0]   len_q, len_d, bit_q, bit_d, len_clamp, cap_shift;
    logic [MAX_LEN-1:0] data_q, data_d, cap_q, cap_d, rsp_q, rsp_d;
    logic [SEQ_W-1:0]   seq_q, seq_d, pre_seq;
    logic [2:0]         seq_cnt_q, seq_cnt_d, pre_cnt;
    logic [TW-1:0]      trst_cnt_q, trst_cnt_d;
    logic               tms_q, tms_d, tdi_q, tdi_d, trst_q, trst_d, auto_q, auto_d;
    logic               run, rise, fall, start;

    jtag_tck_gen #(.DIV(DIV)) u_tck_gen (
        .clk_i      (sys_clk_i),
        .rst_i      (reset_i),
        .run_i      (run),
        .tck_o      (tck_o),
        .rise_stb_o (rise),
        .fall_stb_o (fall)
    );

    assign run         = (state_q == ST_PRE) || (state_q == ST_SHIFT) || (state_q == ST_POST);
    assign cmd_ready_o = ((state_q == ST_IDLE) || (state_q == ST_RESP)) && !auto_q;
    assign rsp_valid_o = (state_q == ST_RESP) && !auto_q;
    assign start       = (cmd_valid_i && cmd_ready_o) || ((state_q == ST_IDLE) && auto_q);
    assign new_op      = auto_q ? OP_TAP_RESET : jtag_op_t'(cmd_op_i);
    assign len_clamp   = (cmd_len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len_i;
    assign pre_seq     = (new_op == OP_SCAN_IR) ? TMS_PRE_IR : TMS_PRE_DR;
    assign pre_cnt     = (new_op == OP_SCAN_IR) ? 3'(TMS_PRE_IR_LEN - 1) : 3'(TMS_PRE_DR_LEN - 1);
    // tdo enters at the MSB, so the first captured bit ends up MAX_LEN-len places up
    assign cap_shift   = LEN_W'(MAX_LEN) - len_q;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        len_d      = len_q;
        bit_d      = bit_q;
        data_d     = data_q;
        cap_d      = cap_q;
        rsp_d      = rsp_q;
        seq_d      = seq_q;
        seq_cnt_d  = seq_cnt_q;
        trst_cnt_d = trst_cnt_q;
        tms_d      = tms_q;
        tdi_d      = tdi_q;
        trst_d     = trst_q;
        auto_d     = auto_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (state_q == ST_RESP) begin
                    state_d = ST_IDLE;
                    auto_d  = 1'b0;
                end
                if (start) begin
                    op_d   = new_op;
                    len_d  = len_clamp;
                    data_d = cmd_data_i;
                    cap_d  = '0;
                    bit_d  = '0;
                    if (new_op == OP_TAP_RESET) begin
                        state_d    = ST_TRST;
                        trst_d     = 1'b0;
                        trst_cnt_d = '0;
                    end else if (len_clamp == '0) begin
                        state_d = ST_RESP;
                        rsp_d   = '0;
                    end else if (new_op == OP_IDLE_CLKS) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d   = ST_PRE;
                        tms_d     = pre_seq[0];
                        seq_d     = pre_seq >> 1;
                        seq_cnt_d = pre_cnt;
                    end
                end
            end
            ST_TRST: begin
                if (trst_cnt_q == TW'(2 * DIV - 1)) begin
                    trst_d    = 1'b1;
                    state_d   = ST_PRE;
                    tms_d     = TMS_RESET[0];
                    seq_d     = TMS_RESET >> 1;
                    seq_cnt_d = 3'(TMS_RESET_LEN - 1);
                end else begin
                    trst_cnt_d = trst_cnt_q + TW'(1);
                end
            end
            ST_PRE, ST_POST: begin
                if (fall) begin
                    if (seq_cnt_q != '0) begin
                        tms_d     = seq_q[0];
                        seq_d     = seq_q >> 1;
                        seq_cnt_d = seq_cnt_q - 3'd1;
                    end else if ((state_q == ST_POST) || (op_q == OP_TAP_RESET)) begin
                        state_d = ST_RESP;
                        tms_d   = 1'b0;
                        rsp_d   = cap_q >> cap_shift;
                    end else begin
                        state_d = ST_SHIFT;
                        tms_d   = (len_q == LEN_W'(1));
                        tdi_d   = data_q[0];
                    end
                end
            end
            ST_SHIFT: begin
                if (rise && (op_q != OP_IDLE_CLKS)) begin
                    cap_d = {tdo_i, cap_q[MAX_LEN-1:1]};
                end
                if (fall) begin
                    if (bit_q == len_q - LEN_W'(1)) begin
                        tdi_d = 1'b0;
                        if (op_q == OP_IDLE_CLKS) begin
                            state_d = ST_RESP;
                            rsp_d   = '0;
                        end else begin
                            state_d   = ST_POST;
                            tms_d     = TMS_POST[0];
                            seq_d     = TMS_POST >> 1;
                            seq_cnt_d = 3'(TMS_POST_LEN - 1);
                        end
                    end else begin
                        bit_d  = bit_q + LEN_W'(1);
                        data_d = data_q >> 1;
                        if (op_q != OP_IDLE_CLKS) begin
                            tms_d = ((bit_q + LEN_W'(2)) == len_q);
                            tdi_d = data_q[1];
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_TAP_RESET;
            len_q      <= '0;
            bit_q      <= '0;
            data_q     <= '0;
            cap_q      <= '0;
            rsp_q      <= '0;
            seq_q      <= '0;
            seq_cnt_q  <= '0;
            trst_cnt_q <= '0;
            tms_q      <= 1'b0;
            tdi_q      <= 1'b0;
            trst_q     <= 1'b1;
            auto_q     <= AUTO_INIT;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            len_q      <= len_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            cap_q      <= cap_d;
            rsp_q      <= rsp_d;
            seq_q      <= seq_d;
            seq_cnt_q  <= seq_cnt_d;
            trst_cnt_q <= trst_cnt_d;
            tms_q      <= tms_d;
            tdi_q      <= tdi_d;
            trst_q     <= trst_d;
            auto_q     <= auto_d;
        end
    end

    assign tms_o      = tms_q;
    assign tdi_o      = tdi_q;
    assign trst_o     = trst_q;
    assign rsp_data_o = rsp_q;

endmodule
